// File: rtl/haar_database_streamer.sv
// Streams one cascade stage's Haar database from ROM, tagging each word with tree/classifier/word indices and end markers.
// Latency: start sampled at edge N, first o_valid at edge N+3, then TOTAL_WORDS back-to-back words, end_database one cycle later.
// No backpressure: the consumer takes one word per cycle; i_abort kills the stream immediately, reset wins over everything.
module haar_database_streamer #(
  parameter int DATA_WIDTH_12  = 12,
  parameter int ADDR_WIDTH     = 12,
  parameter int TREE_WORDS     = 18,
  parameter int NUM_TREE       = 3,
  parameter int NUM_CLASSIFIER = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  output logic [ADDR_WIDTH-1:0]    o_rom_addr,
  input  logic [DATA_WIDTH_12-1:0] i_rom_data,
  output logic [DATA_WIDTH_12-1:0] o_data,
  output logic                     o_valid,
  output logic [DATA_WIDTH_12-1:0] o_index_tree,
  output logic [DATA_WIDTH_12-1:0] o_index_classifier,
  output logic [DATA_WIDTH_12-1:0] o_index_database,
  output logic                     o_end_tree,
  output logic                     o_end_single_classifier,
  output logic                     o_end_all_classifier,
  output logic                     o_end_database,
  output logic                     o_busy
);

  localparam int TOTAL_WORDS = TREE_WORDS * NUM_TREE * NUM_CLASSIFIER;
  localparam logic [DATA_WIDTH_12-1:0] W_LAST = DATA_WIDTH_12'(TREE_WORDS - 1);
  localparam logic [DATA_WIDTH_12-1:0] T_LAST = DATA_WIDTH_12'(NUM_TREE - 1);
  localparam logic [DATA_WIDTH_12-1:0] C_LAST = DATA_WIDTH_12'(NUM_CLASSIFIER - 1);
  localparam logic [DATA_WIDTH_12-1:0] K_LAST = DATA_WIDTH_12'(TOTAL_WORDS - 1);
  localparam logic [DATA_WIDTH_12-1:0] ONE    = DATA_WIDTH_12'(1);
  localparam logic [ADDR_WIDTH-1:0]    A_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0]    addr;      // next ROM address to issue
  logic                     addr_vld;  // o_rom_addr holds a real request
  logic                     data_vld;  // i_rom_data answers a real request
  logic [DATA_WIDTH_12-1:0] w;         // word within tree
  logic [DATA_WIDTH_12-1:0] t;         // tree within classifier
  logic [DATA_WIDTH_12-1:0] c;         // classifier within stage
  logic [DATA_WIDTH_12-1:0] k;         // word within stage
  logic                     take;
  logic                     last;
  logic                     abort;

  // ROM data lags the address by one cycle, so words are captured only once data_vld is up
  assign take  = (state == STREAM) && data_vld;
  assign last  = take && (k == K_LAST);
  assign abort = i_abort && (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: abort from any busy state returns to IDLE, start only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = FETCH;
      FETCH:   state_nxt = abort ? IDLE : STREAM;
      STREAM:  begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // address issue, word capture, counters and markers
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      addr                    <= '0;
      addr_vld                <= 1'b0;
      data_vld                <= 1'b0;
      w                       <= '0;
      t                       <= '0;
      c                       <= '0;
      k                       <= '0;
      o_rom_addr              <= '0;
      o_data                  <= '0;
      o_valid                 <= 1'b0;
      o_index_tree            <= '0;
      o_index_classifier      <= '0;
      o_index_database        <= '0;
      o_end_tree              <= 1'b0;
      o_end_single_classifier <= 1'b0;
      o_end_all_classifier    <= 1'b0;
      o_end_database          <= 1'b0;
      o_busy                  <= 1'b0;
    end else begin
      o_end_database <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr   <= i_base_addr;
            o_busy <= 1'b1;
            w      <= '0;
            t      <= '0;
            c      <= '0;
            k      <= '0;
          end
        end
        FETCH: begin
          o_rom_addr <= addr;
          addr       <= addr + A_ONE;
          addr_vld   <= 1'b1;
        end
        STREAM: begin
          o_rom_addr <= addr;
          addr       <= addr + A_ONE;
          data_vld   <= addr_vld;
          if (take) begin
            o_valid                 <= 1'b1;
            o_data                  <= i_rom_data;
            o_index_tree            <= t;
            o_index_classifier      <= c;
            o_index_database        <= k;
            o_end_tree              <= (w == W_LAST);
            o_end_single_classifier <= (w == W_LAST) && (t == T_LAST);
            o_end_all_classifier    <= (w == W_LAST) && (t == T_LAST) && (c == C_LAST);
            k                       <= k + ONE;
            if (w == W_LAST) begin
              w <= '0;
              if (t == T_LAST) begin
                t <= '0;
                c <= c + ONE;
              end else begin
                t <= t + ONE;
              end
            end else begin
              w <= w + ONE;
            end
          end
        end
        FINISH: begin
          addr_vld                <= 1'b0;
          data_vld                <= 1'b0;
          o_data                  <= '0;
          o_valid                 <= 1'b0;
          o_index_tree            <= '0;
          o_index_classifier      <= '0;
          o_index_database        <= '0;
          o_end_tree              <= 1'b0;
          o_end_single_classifier <= 1'b0;
          o_end_all_classifier    <= 1'b0;
          o_end_database          <= 1'b1;
          o_busy                  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_haar_database_streamer.sv
// Directed bench for haar_database_streamer with a timeline model of the stream.
// Model predicts every output from cycles elapsed since start acceptance.
// ROM is a 1-cycle registered lookup ROM[a] = a ^ 12'hA5A.
module tb_haar_database_streamer;

  localparam int TW    = 3;
  localparam int NT    = 2;
  localparam int NC    = 2;
  localparam int TOTAL = TW * NT * NC;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [11:0] base;
  logic [11:0] rom_addr, rom_data;
  logic [11:0] o_data, o_index_tree, o_index_classifier, o_index_database;
  logic        o_valid, o_end_tree, o_end_single_classifier, o_end_all_classifier;
  logic        o_end_database, o_busy;

  int n_chk  = 0;
  int n_pass = 0;

  haar_database_streamer #(
    .DATA_WIDTH_12(12), .ADDR_WIDTH(12),
    .TREE_WORDS(TW), .NUM_TREE(NT), .NUM_CLASSIFIER(NC)
  ) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
    .i_base_addr(base), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_data(o_data), .o_valid(o_valid),
    .o_index_tree(o_index_tree), .o_index_classifier(o_index_classifier),
    .o_index_database(o_index_database),
    .o_end_tree(o_end_tree), .o_end_single_classifier(o_end_single_classifier),
    .o_end_all_classifier(o_end_all_classifier), .o_end_database(o_end_database),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // registered ROM, one cycle of read latency
  always @(posedge clk) rom_data <= rom_addr ^ 12'hA5A;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // timeline model: age = edges since the start was accepted
  bit          chk_en = 0;
  bit          m_busy = 0;
  bit          m_endb = 0;
  bit          m_zero = 0;
  int          m_age  = 0;
  logic [11:0] m_base = '0;

  always @(posedge clk) begin
    m_endb = 0;
    m_zero = 0;
    if (reset) begin
      m_busy = 0; m_age = 0; m_zero = 1;
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_age = 0; m_zero = 1;
      end else begin
        m_age++;
        if (m_age == TOTAL + 3) begin
          m_busy = 0; m_endb = 1;
        end
      end
    end else if (start) begin
      m_busy = 1; m_age = 0; m_base = base;
    end
    chk_en = 1;
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    bit   ev;
    int   k;
    logic [5:0] exp_ctrl;
    if (chk_en) begin
      ev = m_busy && (m_age >= 3) && (m_age <= TOTAL + 2);
      k  = m_age - 3;
      exp_ctrl = {ev, m_busy, m_endb,
                  ev && (k % TW == TW - 1),
                  ev && (k % (TW * NT) == TW * NT - 1),
                  ev && (k == TOTAL - 1)};
      chk("ctrl", 64'({o_valid, o_busy, o_end_database, o_end_tree,
                       o_end_single_classifier, o_end_all_classifier}), 64'(exp_ctrl));
      if (ev)
        chk("word", 64'({o_data, o_index_tree, o_index_classifier, o_index_database}),
            64'({(m_base + 12'(k)) ^ 12'hA5A, 12'((k / TW) % NT), 12'(k / (TW * NT)), 12'(k)}));
      if (m_zero)
        chk("zero", 64'({o_data, o_index_tree, o_index_classifier, o_index_database, rom_addr}), 64'(0));
    end
  end

  task automatic start_pulse(input logic [11:0] b, input logic with_abort);
    base  = b;
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_k(input int kk);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (o_valid && o_index_database == 12'(kk)) ok = 1;
    end
    chk("wait_k", 64'(ok), 64'(1));
  endtask

  task automatic first_valid(output int lat);
    bit ok = 0;
    lat = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (o_valid) ok = 1;
    end
    chk("first_valid", 64'(ok), 64'(1));
  endtask

  task automatic count_to_end(output int nvalid);
    bit ok = 0;
    nvalid = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (o_valid) nvalid++;
      if (o_end_database) ok = 1;
    end
    chk("end_database_seen", 64'(ok), 64'(1));
  endtask

  initial begin
    int lat, nv;
    bit wrapped;
    logic [11:0] prev, got0, got6;

    reset = 1'b1; start = 1'b0; abort = 1'b0; base = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({o_valid, o_busy, o_end_database, rom_addr}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // 1: base 0x010 full stream
    start_pulse(12'h010, 1'b0);
    chk("busy_on_accept", 64'(o_busy), 64'(1));
    first_valid(lat);
    chk("latency", 64'(lat), 64'(3));
    chk("t1_first", 64'({o_data, o_index_database}), 64'({12'hA4A, 12'd0}));
    wait_k(11);
    chk("t1_last", 64'({o_data, o_end_all_classifier, o_end_single_classifier, o_end_tree}),
        64'({12'hA41, 3'b111}));
    @(negedge clk);
    chk("t1_end_database", 64'({o_end_database, o_valid, o_busy}), 64'(3'b100));

    // 6: back-to-back start during the end_database cycle
    start_pulse(12'h010, 1'b0);
    count_to_end(nv);
    chk("t6_words", 64'(nv), 64'(12));
    repeat (2) @(negedge clk);

    // abort in IDLE is ignored
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", 64'(o_busy), 64'(0));

    // 2: abort at the 4th word, then replay (start+abort together in IDLE = start)
    start_pulse(12'h020, 1'b0);
    wait_k(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t2_abort", 64'({o_valid, o_busy, o_end_database}), 64'(0));
    repeat (20) @(negedge clk);
    start_pulse(12'h020, 1'b1);
    first_valid(lat);
    chk("t2_replay", 64'({o_data, o_index_database}), 64'({12'hA7A, 12'd0}));

    // 3: start pulse mid-stream is ignored
    wait_k(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_no_restart", 64'(o_index_database), 64'(7));
    count_to_end(nv);
    chk("t3_remaining", 64'(nv), 64'(4));
    repeat (2) @(negedge clk);

    // 4: reset mid-stream
    start_pulse(12'h030, 1'b0);
    wait_k(7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_reset", 64'({o_valid, o_busy, o_end_database, o_data, o_index_database, rom_addr}), 64'(0));
    repeat (20) @(negedge clk);

    // 5: address wrap from 0xFFF to 0x000
    wrapped = 0; got0 = '0; got6 = '0;
    start_pulse(12'hFFA, 1'b0);
    for (int i = 0; i < 40; i++) begin
      prev = rom_addr;
      @(negedge clk);
      if (prev == 12'hFFF && rom_addr == 12'h000) wrapped = 1;
      if (o_valid && o_index_database == 12'd0) got0 = o_data;
      if (o_valid && o_index_database == 12'd6) got6 = o_data;
      if (o_end_database) break;
    end
    chk("t5_addr_wrap", 64'(wrapped), 64'(1));
    chk("t5_word0", 64'(got0), 64'(12'h5A0));
    chk("t5_word6", 64'(got6), 64'(12'hA5A));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
